data_rec_submodule: RTL
=======================

// Module: data_rec_submodule
// PURPOSE
//  Receive-side capture for the 8-channel 12-bit echo data bus (Data_A..Data_H).
//  On a trigger it waits a programmed delay, then samples one 8-channel frame
//  every DECIM clocks for NUM_FRAMES frames. Frames are buffered in a frame FIFO,
//  then serialised into a tagged 16-bit word stream with valid/ready handshake.
//  Sits between the front-end data source and the downstream beamform/DMA path.
// PARAMETERS
//  DELAY_CYC   4   clocks from trigger acceptance to the first sample edge
//  DECIM       8   clocks between frame samples; legal range >= 8
//  NUM_FRAMES  16  frames attempted per trigger
//  FIFO_DEPTH  4   frame FIFO depth in 96-bit frames; power of 2
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   async active-low reset
//  trig       in   1   capture start; level-sampled, accepted only in IDLE
//  Data_A..H  in   12  channel samples 0..7, A = ch0 through H = ch7
//  out_data   out  16  [15]=first-of-frame, [14:12]=channel idx, [11:0]=sample
//  out_valid  out  1   out_data is valid
//  out_ready  in   1   downstream accepts; a transfer occurs when valid & ready
//  busy       out  1   high in every state except IDLE
//  overflow   out  1   sticky; a frame was dropped because the FIFO was full
//  done       out  1   one-cycle pulse when DRAIN completes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all counters 0, FIFO empty;
//   out_data=0, out_valid=0, busy=0, overflow=0, done=0.
//   Partially captured or queued data is discarded.
//  FSM states: IDLE, DELAY, CAPTURE, DRAIN.
//   IDLE: trig=1 at edge T -> DELAY. Clear overflow. Load delay count.
//   DELAY: stays DELAY_CYC clocks. First sample edge is S0 = T+DELAY_CYC+1.
//     At S0 -> CAPTURE.
//   CAPTURE: sample edges Sk = S0 + k*DECIM for k = 0..NUM_FRAMES-1.
//     Frame count increments on each sample edge, whether written or dropped.
//     After edge S(NUM_FRAMES-1) -> DRAIN.
//   DRAIN: -> IDLE when the FIFO is empty, the serialiser is idle, and no
//     transfer is pending. done=1 for exactly that one cycle.
//  trig is ignored outside IDLE; a held trig retriggers only after returning to IDLE.
//  Sample edge: {H,G,F,E,D,C,B,A} is registered into the FIFO as one 96-bit frame.
//   If the FIFO is full, the frame is dropped and overflow=1 from the next cycle.
//   overflow holds until the next accepted trigger or reset.
//   A simultaneous FIFO pop and full-FIFO write both succeed (pop frees the slot).
//  Serialiser pops one frame and emits 8 words in order ch0..ch7.
//   Word bit [15] is set only on ch0.
//   out_data and out_valid are registered and must stay stable until accepted.
//   Advance to the next word only on valid & ready.
//   After ch7 is accepted, the next frame's ch0 may be valid in the same next cycle.
//     No bubble is permitted if a frame is queued.
//  Latency: frame sampled at edge S into an empty pipe -> ch0 out_valid=1 from edge S+2.
//  With out_ready held at 1, throughput is one word per clock.
//   DECIM>=8 therefore guarantees no overflow.
//  Pointers wrap modulo FIFO_DEPTH; full/empty are tracked with an extra wrap bit.
// TESTING
//  1 Latency: trig at edge 10, DELAY_CYC=4 -> busy=1 from edge 11.
//    First sample at edge 15; out_valid with ch0 from edge 17.
//  2 Ordering: Data_A..H=0x100..0x107, out_ready=1 -> words 0x8100,0x1101..0x7107.
//    Then, after 16 frames (128 words), done pulses once and overflow=0.
//  3 Backpressure: out_ready=0 for 60 clocks mid-CAPTURE.
//    Exactly 4 frames are queued, the subsequent frames drop, and overflow=1.
//    On release, the queued words come out intact; overflow clears on the next trig.
//  4 Trig while busy: pulse trig during CAPTURE and DRAIN.
//    Frame count and timing are unchanged; no extra frames are produced.
//  5 Reset mid-operation: reset_n=0 during CAPTURE with words pending.
//    All outputs are 0 immediately; a new trig gives a clean run equal to scenario 2.
//  6 Stall stability: toggle out_ready randomly.
//    out_data must never change while out_valid=1 and out_ready=0.
//    No word is lost or duplicated (scoreboard).

Source files
------------

// File: rtl/data_rec_submodule.sv
// Receive-side capture for the 8-channel 12-bit echo bus.
// A trigger starts a delayed, decimated capture of NUM_FRAMES frames into a
// frame FIFO. A serialiser turns each frame into eight tagged 16-bit words.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   trig              capture start, accepted only while idle
//   Data_A..Data_H    channel samples ch0..ch7
//   out_data          {first_of_frame, ch_idx[2:0], sample[11:0]}
//   out_valid         out_data holds a word
//   out_ready         downstream accept; transfer on valid & ready
//   busy              capture sequence in progress (registered from state)
//   overflow          sticky frame-drop flag, cleared by the next trigger
//   done              one-cycle pulse when the drain completes
module data_rec_submodule #(
  parameter int unsigned DELAY_CYC  = 4,
  parameter int unsigned DECIM      = 8,
  parameter int unsigned NUM_FRAMES = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trig,
  input  logic [11:0] Data_A,
  input  logic [11:0] Data_B,
  input  logic [11:0] Data_C,
  input  logic [11:0] Data_D,
  input  logic [11:0] Data_E,
  input  logic [11:0] Data_F,
  input  logic [11:0] Data_G,
  input  logic [11:0] Data_H,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned FRAME_W  = SAMPLE_W * NUM_CH;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W    = AW + 1;
  localparam int unsigned DLY_W    = (DELAY_CYC > 0) ? $clog2(DELAY_CYC + 1) : 1;
  localparam int unsigned DEC_W    = $clog2(DECIM);
  localparam int unsigned FRM_W    = $clog2(NUM_FRAMES + 1);
  localparam int unsigned SER_W    = $clog2(NUM_CH + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DELAY   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FRAME_W-1:0]  ser_frame_q, ser_frame_d;
  logic [SER_W-1:0]    ser_cnt_q, ser_cnt_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [FRAME_W-1:0]  mem_q [FIFO_DEPTH];

  logic                fifo_empty_c, fifo_full_c;
  logic                out_take_c, pop_c, sample_c, push_c, drop_c;
  logic [2:0]          ch_idx_c;

  // Frame FIFO status; the extra pointer bit separates full from empty.
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Serialiser moves a word into the output register whenever it is free or draining.
  assign out_take_c = (ser_cnt_q != '0) && (!out_valid_q || out_ready);
  // Refill the serialiser as its last word leaves, so frames stream without a bubble.
  assign pop_c      = !fifo_empty_c &&
                      ((ser_cnt_q == '0) || ((ser_cnt_q == SER_W'(1)) && out_take_c));
  assign sample_c   = ((state_q == ST_DELAY) && (dly_q == '0)) ||
                      ((state_q == ST_CAPTURE) && (dec_q == '0));
  // A pop in the same cycle frees a slot for a write into a full FIFO.
  assign push_c     = sample_c && (!fifo_full_c || pop_c);
  assign drop_c     = sample_c && fifo_full_c && !pop_c;
  assign ch_idx_c   = 3'(SER_W'(NUM_CH) - ser_cnt_q);

  // Next-state, counters, FIFO pointers and serialiser.
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    dec_d       = dec_q;
    frm_d       = frm_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    busy_d      = (state_q != ST_IDLE);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ser_frame_d = ser_frame_q;
    ser_cnt_d   = ser_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_DELAY;
          dly_d   = DLY_W'(DELAY_CYC);
          frm_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_DELAY: begin
        if (dly_q != '0) dly_d = dly_q - DLY_W'(1);
      end
      ST_CAPTURE: begin
        if (dec_q != '0) dec_d = dec_q - DEC_W'(1);
      end
      ST_DRAIN: begin
        if (fifo_empty_c && (ser_cnt_q == '0) && !out_valid_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every sample edge counts a frame, whether it is stored or dropped.
    if (sample_c) begin
      frm_d   = frm_q + FRM_W'(1);
      dec_d   = DEC_W'(DECIM - 1);
      state_d = (frm_q == FRM_W'(NUM_FRAMES - 1)) ? ST_DRAIN : ST_CAPTURE;
    end

    if (drop_c) ovf_d = 1'b1;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (out_take_c) begin
      out_valid_d = 1'b1;
      out_data_d  = {(ser_cnt_q == SER_W'(NUM_CH)), ch_idx_c, ser_frame_q[SAMPLE_W-1:0]};
      ser_frame_d = ser_frame_q >> SAMPLE_W;
      ser_cnt_d   = ser_cnt_q - SER_W'(1);
    end
    if (pop_c) begin
      ser_frame_d = mem_q[rd_ptr_q[AW-1:0]];
      ser_cnt_d   = SER_W'(NUM_CH);
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dly_q       <= '0;
      dec_q       <= '0;
      frm_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ser_frame_q <= '0;
      ser_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      dec_q       <= dec_d;
      frm_q       <= frm_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ser_frame_q <= ser_frame_d;
      ser_cnt_q   <= ser_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Frame storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= {Data_H, Data_G, Data_F, Data_E,
                                           Data_D, Data_C, Data_B, Data_A};
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign done      = done_q;

endmodule
